fifo_buf: RTL and testbench
===========================

// Module: fifo_buf
// PURPOSE
//  Parametrised synchronous FIFO; next generation of the enable/reset flop: DEPTH entries of WIDTH bits
//  instead of one register. Valid/ready handshake on both sides. Buffers move and event words between
//  game-control FSMs and display/IO logic, one push and one pop per cycle.
// PARAMETERS
//  WIDTH  8  data word width in bits, >=1
//  DEPTH  4  number of entries, >=2, need not be a power of two
// PORTS
//  clk        in   1                    single clock, all state updates on rising edge
//  reset      in   1                    asynchronous, active-high; clears all control state
//  in_valid   in   1                    producer offers in_data
//  in_ready   out  1                    FIFO can accept a word (not full)
//  in_data    in   WIDTH                write data
//  out_valid  out  1                    FIFO holds at least one word (not empty)
//  out_ready  in   1                    consumer takes out_data this cycle
//  out_data   out  WIDTH                oldest word; all-zero when out_valid=0
//  count      out  $clog2(DEPTH+1)      current occupancy, 0..DEPTH
//  flush      in   1                    present only with FIFO_FLUSH_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1, out_data=0.
//    Storage array is not reset. Reset mid-operation discards all stored words immediately.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Only registered state drives in_ready and
//    out_valid; neither depends combinationally on in_valid or out_ready.
//  - Push writes in_data at wr_ptr. Pop advances rd_ptr. Each pointer wraps DEPTH-1 -> 0.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither. in_ready = (count!=DEPTH),
//    out_valid = (count!=0).
//  - First-word fall-through: out_data = mem[rd_ptr] combinationally while out_valid=1.
//  - Latency: a word pushed in cycle N is visible at out_valid/out_data in cycle N+1. No bypass when empty.
//  - Full with in_valid & out_ready: pop proceeds, push refused (in_ready=0). Next cycle count=DEPTH-1, in_ready=1.
//  - Empty with in_valid & out_ready: push proceeds, no pop. Next cycle count=1.
//  - in_valid while full: the word is not taken; the producer must hold it. in_data is sampled only on push.
//  - Order is strict FIFO. No word is dropped or duplicated except by reset or flush.
// CONFIGURATION
//  - Macro FIFO_FLUSH_EN. When defined, adds input port flush. flush=1 at a rising edge sets wr_ptr=rd_ptr=0
//    and count=0. A push or pop in that same cycle is ignored. in_ready/out_valid in the flush cycle still
//    reflect the pre-flush state; the producer must not count that handshake as accepted.
//  - When undefined, there is no flush port and only reset clears the FIFO.
// STRUCTURE
//  - Shared package lib_pkg: function clog2_ceil and typedef for pointer width, reused by later buffers.
//  - Sub-module wrap_ctr #(MAX): enable-gated counter with synchronous clear and wrap MAX-1 -> 0, async reset.
//    Two instances: write pointer and read pointer. count is a separate up/down register in fifo_buf.
//  - Storage: flat reg array written on push. No latches. All sequential logic in always_ff with async reset.
// TESTING
//  - Reset, then idle: in_ready=1, out_valid=0, count=0, out_data=0. Assert reset mid-traffic -> same values at once.
//  - WIDTH=8, DEPTH=4: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0. Fifth push 0x55 is not taken.
//  - Drain the full FIFO with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0.
//  - Full with in_valid=1, out_ready=1 -> pop 0x11, push refused, count=3. Next cycle push accepted, count=4.
//  - DEPTH=3, 10 cycles of continuous push+pop -> pointers wrap correctly, order preserved, count constant.
//  - FIFO_FLUSH_EN: 2 words stored, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, word dropped.

Source files
------------

// File: rtl/lib_pkg.sv
// Shared helpers for the buffer family: pointer-width arithmetic and a common pointer type.
package lib_pkg;

    localparam int PTR_W_MAX = 16;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    // Bits needed to index n distinct values (at least one bit).
    function automatic int clog2_ceil(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wrap_ctr.sv
// Enable-gated modulo-MAX counter with synchronous clear; used for the FIFO read/write pointers.
module wrap_ctr
    import lib_pkg::*;
#(
    parameter int MAX = 4,
    localparam int W = clog2_ceil(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (en) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/fifo_buf.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Optional synchronous flush input is built in when FIFO_FLUSH_EN is defined.
module fifo_buf
    import lib_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FIFO_FLUSH_EN
    ,
    input  logic                       flush
`endif
);

    localparam int PTR_W = clog2_ceil(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             flush_i;

`ifdef FIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Handshake flags come only from the occupancy register, never from the partner's valid/ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    wrap_ctr #(.MAX(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .en    (push),
        .value (wr_ptr)
    );

    wrap_ctr #(.MAX(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .en    (pop),
        .value (rd_ptr)
    );

    // Storage is deliberately left unreset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_buf.sv
// Self-checking bench for fifo_buf: directed scenarios plus randomized traffic against a queue model.
// Exercises the flush port when FIFO_FLUSH_EN is defined.
module tb_fifo_buf;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    logic       b_flush;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_in_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [7:0] b_out_data;
    logic [1:0] b_count;

    int checks;
    int passed;

    logic [7:0] model_q[$];

    fifo_buf #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef FIFO_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    fifo_buf #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
`ifdef FIFO_FLUSH_EN
        ,
        .flush     (b_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // Advance one clock; the queue model follows the handshake rules for the DEPTH=4 instance.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (model_q.size() < 4);
        do_pop  = out_ready && (model_q.size() > 0);
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (count !== 3'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if (out_data !== 8'h00) $display("[TB] FAIL reset_out_data got %h want 00", out_data); else passed++;
        reset = 1'b0;
        model_q.delete();
        cycle();
        checks++; if (count !== 3'd0) $display("[TB] FAIL idle_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL idle_out_valid got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_fill();
        logic [7:0] d;
        for (int i = 1; i <= 4; i++) begin
            d = 8'(8'h11 * i);
            applyStimulus(1'b1, d, 1'b0);
            cycle();
            checks++; if (count !== 3'(i)) $display("[TB] FAIL fill_count got %0d want %0d", count, i); else passed++;
        end
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL full_in_ready got %b want 0", in_ready); else passed++;
        checks++; if (out_data !== 8'h11) $display("[TB] FAIL full_head got %h want 11", out_data); else passed++;
        applyStimulus(1'b1, 8'h55, 1'b0);
        cycle();
        checks++; if (count !== 3'd4) $display("[TB] FAIL fifth_push_count got %0d want 4", count); else passed++;
        checks++; if (out_data !== 8'h11) $display("[TB] FAIL fifth_push_head got %h want 11", out_data); else passed++;
    endtask

    task automatic test_drain();
        logic [7:0] d;
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            d = 8'(8'h11 * i);
            checks++; if (out_data !== d) $display("[TB] FAIL drain_data got %h want %h", out_data, d); else passed++;
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL drain_valid got %b want 1", out_valid); else passed++;
            cycle();
        end
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL drained_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_data !== 8'h00) $display("[TB] FAIL drained_data got %h want 00", out_data); else passed++;
        checks++; if (count !== 3'd0) $display("[TB] FAIL drained_count got %0d want 0", count); else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(8'h11 * i), 1'b0);
            cycle();
        end
        applyStimulus(1'b1, 8'h55, 1'b1);
        checks++; if (out_data !== 8'h11) $display("[TB] FAIL fullpp_head got %h want 11", out_data); else passed++;
        cycle();
        checks++; if (count !== 3'd3) $display("[TB] FAIL fullpp_count got %0d want 3", count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL fullpp_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_data !== 8'h22) $display("[TB] FAIL fullpp_next got %h want 22", out_data); else passed++;
        applyStimulus(1'b1, 8'h55, 1'b0);
        cycle();
        checks++; if (count !== 3'd4) $display("[TB] FAIL fullpp_refill got %0d want 4", count); else passed++;
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            checks++; if (out_data !== 8'(8'h11 * i)) $display("[TB] FAIL fullpp_order got %h want %h", out_data, 8'(8'h11 * i)); else passed++;
            cycle();
        end
    endtask

    task automatic test_empty_push_pop();
        applyStimulus(1'b1, 8'h66, 1'b1);
        cycle();
        checks++; if (count !== 3'd1) $display("[TB] FAIL emptypp_count got %0d want 1", count); else passed++;
        checks++; if (out_data !== 8'h66) $display("[TB] FAIL emptypp_data got %h want 66", out_data); else passed++;
        applyStimulus(1'b0, 8'h00, 1'b1);
        cycle();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL emptypp_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 8'h00, 1'b0);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hA0;
        cycle();
        b_in_data   = 8'hA1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            b_in_data   = 8'(8'hA2 + i);
            b_out_ready = 1'b1;
            checks++; if (b_out_data !== 8'(8'hA0 + i)) $display("[TB] FAIL b2b_data got %h want %h", b_out_data, 8'(8'hA0 + i)); else passed++;
            checks++; if (b_count !== 2'd2) $display("[TB] FAIL b2b_count got %0d want 2", b_count); else passed++;
            cycle();
        end
        checks++; if (b_out_data !== 8'hAA) $display("[TB] FAIL b2b_final got %h want aa", b_out_data); else passed++;
        b_in_valid = 1'b0;
        cycle();
        cycle();
        checks++; if (b_out_valid !== 1'b0) $display("[TB] FAIL b2b_empty got %b want 0", b_out_valid); else passed++;
        b_out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_data;
        for (int i = 0; i < 300; i++) begin
            if (i < 150) applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
            else         applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
            exp_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
            checks++; if (count !== 3'(model_q.size())) $display("[TB] FAIL rand_count got %0d want %0d", count, model_q.size()); else passed++;
            checks++; if (out_data !== exp_data) $display("[TB] FAIL rand_data got %h want %h", out_data, exp_data); else passed++;
            checks++; if (in_ready !== (model_q.size() < 4)) $display("[TB] FAIL rand_in_ready got %b want %b", in_ready, model_q.size() < 4); else passed++;
            checks++; if (out_valid !== (model_q.size() > 0)) $display("[TB] FAIL rand_out_valid got %b want %b", out_valid, model_q.size() > 0); else passed++;
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 8'h77, 1'b0);
        cycle();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0) $display("[TB] FAIL midreset_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midreset_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midreset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_data !== 8'h00) $display("[TB] FAIL midreset_data got %h want 00", out_data); else passed++;
        applyStimulus(1'b0, 8'h00, 1'b0);
        model_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

`ifdef FIFO_FLUSH_EN
    task automatic test_flush();
        applyStimulus(1'b1, 8'h31, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h32, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h99, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checks++; if (count !== 3'd0) $display("[TB] FAIL flush_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid got %b want 0", out_valid); else passed++;
        cycle();
        checks++; if (count !== 3'd0) $display("[TB] FAIL flush_dropped got %0d want 0", count); else passed++;
        applyStimulus(1'b1, 8'h42, 1'b0);
        cycle();
        checks++; if (out_data !== 8'h42) $display("[TB] FAIL flush_restart got %h want 42", out_data); else passed++;
        applyStimulus(1'b0, 8'h00, 1'b1);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask
`endif

    initial begin
        checks      = 0;
        passed      = 0;
        flush       = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h00;
        b_out_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef FIFO_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
